// File: rtl/aes128_byte_loader_if.sv
// Signal bundle between the byte loader, its upstream byte source, the AES core
// and the ciphertext consumer.
interface aes128_byte_loader_if;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_reuse_key;
  logic [0:127] core_plaintext;
  logic [0:127] core_key;
  logic [0:127] core_en_msg;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] out_data;
  logic         key_loaded;

  modport slave (
    input  in_valid, in_data, in_reuse_key, core_en_msg, out_ready,
    output in_ready, core_plaintext, core_key, out_valid, out_data, key_loaded
  );

  modport master (
    output in_valid, in_data, in_reuse_key, core_en_msg, out_ready,
    input  in_ready, core_plaintext, core_key, out_valid, out_data, key_loaded
  );
endinterface

// File: rtl/aes128_byte_loader.sv
// Byte-serial loader for a combinational AES-128 core: assembles key/plaintext
// bytes, waits for the core to settle, and hands the ciphertext downstream.
module aes128_byte_loader #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  aes128_byte_loader_if.slave    bus
);

  typedef enum logic [1:0] {LOAD_KEY, LOAD_PT, SETTLE, OUTPUT} state_e;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_e       state_q, state_d;
  logic [3:0]   byte_cnt_q, byte_cnt_d;
  logic [3:0]   settle_cnt_q, settle_cnt_d;
  logic [0:127] key_q, key_d;
  logic [0:127] pt_q, pt_d;
  logic [0:127] out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;
  logic         key_loaded_q, key_loaded_d;
  logic         in_ready;
  logic         xfer;
  logic [6:0]   byte_pos;

  assign in_ready = (state_q == LOAD_KEY) || (state_q == LOAD_PT);
  assign xfer     = bus.in_valid && in_ready;
  // Byte 0 lands in bits [0:7], i.e. FIPS-197 hex-string order.
  assign byte_pos = {byte_cnt_q, 3'b000};

  // NOTE: every _d gets its hold value first so no path through the case
  // leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    settle_cnt_d = settle_cnt_q;
    key_d        = key_q;
    pt_d         = pt_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    key_loaded_d = key_loaded_q;

    case (state_q)
      LOAD_KEY: begin
        if (xfer) begin
          if (byte_cnt_q == 4'd0 && bus.in_reuse_key && key_loaded_q) begin
            pt_d[0:7]  = bus.in_data;
            byte_cnt_d = 4'd1;
            state_d    = LOAD_PT;
          end else begin
            key_d[byte_pos +: 8] = bus.in_data;
            if (byte_cnt_q == 4'd0) key_loaded_d = 1'b0;
            if (byte_cnt_q == 4'd15) begin
              key_loaded_d = 1'b1;
              byte_cnt_d   = 4'd0;
              state_d      = LOAD_PT;
            end else begin
              byte_cnt_d = byte_cnt_q + 4'd1;
            end
          end
        end
      end

      LOAD_PT: begin
        if (xfer) begin
          pt_d[byte_pos +: 8] = bus.in_data;
          if (byte_cnt_q == 4'd15) begin
            byte_cnt_d   = 4'd0;
            settle_cnt_d = 4'd0;
            state_d      = SETTLE;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
      end

      SETTLE: begin
        // Core inputs have been stable since the last byte; capture once the
        // configured propagation time has elapsed.
        if (settle_cnt_q == SETTLE_LAST) begin
          out_data_d   = bus.core_en_msg;
          out_valid_d  = 1'b1;
          settle_cnt_d = 4'd0;
          state_d      = OUTPUT;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end

      OUTPUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          byte_cnt_d  = 4'd0;
          state_d     = LOAD_KEY;
        end
      end

      default: state_d = LOAD_KEY;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD_KEY;
      byte_cnt_q   <= 4'd0;
      settle_cnt_q <= 4'd0;
      key_q        <= '0;
      pt_q         <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      key_loaded_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      key_q        <= key_d;
      pt_q         <= pt_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      key_loaded_q <= key_loaded_d;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.core_key       = key_q;
  assign bus.core_plaintext = pt_q;
  assign bus.out_data       = out_data_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.key_loaded     = key_loaded_q;

endmodule

// File: doc/aes128_byte_loader.md
# aes128_byte_loader

Byte-serial front end for the combinational `aes128_encryption` core. It accepts key and plaintext bytes over a valid/ready stream and assembles them into the core's 128-bit `plaintext` and `key` inputs. It waits a fixed settle time for the core to propagate, then captures `en_msg` and presents the ciphertext on a valid/ready output. The block sits directly upstream of the core and instantiates nothing itself. The core is wired alongside it at the next level up.

## Interface
Parameters:
- SETTLE_CYCLES, 2, number of cycles `core_plaintext`/`core_key` are held stable before `core_en_msg` is captured. Legal range is 1..15.

Ports:
- clk  in  1  single clock; all logic is on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input byte valid
- in_ready  out  1  block can accept a byte
- in_data  in  8  input byte
- in_reuse_key  in  1  sampled only with the first byte of a frame; requests a plaintext-only frame
- core_plaintext  out  [0:127]  to core `plaintext`
- core_key  out  [0:127]  to core `key`
- core_en_msg  in  [0:127]  from core `en_msg`
- out_valid  out  1  ciphertext valid
- out_ready  in  1  consumer accepts ciphertext
- out_data  out  [0:127]  captured ciphertext
- key_loaded  out  1  a complete key has been loaded and not invalidated since reset

## Operation
- Byte ordering:
  - The first byte of a 16-byte group lands in bits [0:7] and the 16th in [120:127].
  - This matches FIPS-197 hex-string order.
- A byte transfer occurs on a rising edge with in_valid && in_ready.
- States: LOAD_KEY, LOAD_PT, SETTLE, OUTPUT. A 4-bit byte counter and a 4-bit settle counter drive the transitions.
- LOAD_KEY (reset state), in_ready=1:
  - First byte of frame with in_reuse_key=1 and key_loaded=1: the byte is plaintext byte 0. key_reg is untouched. Next state is LOAD_PT with counter=1.
  - First byte with in_reuse_key=0, or with in_reuse_key=1 and key_loaded=0: the byte is key byte 0. key_loaded clears on this edge.
  - Each key byte is written into core_key at the counter position.
  - The 16th key byte sets key_loaded=1, wraps the counter to 0, and moves to LOAD_PT.
- LOAD_PT, in_ready=1:
  - Each byte is written into core_plaintext at the counter position. in_reuse_key is ignored.
  - The 16th byte moves to SETTLE with settle counter=0.
- SETTLE, in_ready=0:
  - The counter increments each cycle.
  - On the edge where it reaches SETTLE_CYCLES-1, out_data <= core_en_msg, out_valid <= 1, and the state moves to OUTPUT.
- OUTPUT, in_ready=0:
  - out_data and out_valid are held until out_valid && out_ready.
  - On that edge, out_valid <= 0 and the state moves to LOAD_KEY (frame start).
- core_plaintext and core_key are registers. They change only on accepted bytes and are stable through SETTLE and OUTPUT.
- in_data is ignored whenever in_ready=0.

## Timing
- in_ready is a combinational decode of the state. It is 1 in LOAD_KEY/LOAD_PT and 0 in SETTLE/OUTPUT.
- Reset (rst=1 at an edge):
  - State goes to LOAD_KEY; both counters go to 0.
  - core_plaintext, core_key and out_data go to 0.
  - out_valid=0 and key_loaded=0.
  - Reset overrides any concurrent transfer, including mid-frame, in SETTLE, and in OUTPUT. A byte offered while rst=1 is dropped.
- Latency: the last plaintext byte is accepted at edge N.
  - out_valid is high after edge N+SETTLE_CYCLES.
  - With out_ready held at 1, out_valid is high for exactly one cycle.
  - in_ready returns after edge N+SETTLE_CYCLES+1.
- Throughput:
  - Full frame: 32 + SETTLE_CYCLES + 1 cycles.
  - Reuse frame: 16 + SETTLE_CYCLES + 1 cycles.
- There is no bypass from out_ready to in_ready. The next frame's first byte is accepted no earlier than the cycle after the output handshake.
- in_valid gaps inside a frame are allowed. There is no timeout.

## Test plan
- FIPS-197 Appendix B, core attached, SETTLE_CYCLES=2:
  - Stimulus: key bytes 2b7e151628aed2a6abf7158809cf4f3c, then plaintext bytes 3243f6a8885a308d313198a2e0370734, in_valid=1 continuously, out_ready=1.
  - Response: out_data=3925841d02dc09fbdc118597196a0b32 with out_valid high exactly 2 edges after the last byte is accepted; key_loaded=1.
- Key reuse:
  - Stimulus: after the Appendix B frame, send 16 plaintext bytes 3243f6a8…0734 with in_reuse_key=1 on byte 0.
  - Response: the same ciphertext 3925841d…0b32; core_key unchanged throughout.
- Key change:
  - Stimulus: in_reuse_key=0, key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff.
  - Response: out_data=69c4e0d86a7b0430d8cdb78070b4c55a; key_loaded drops on the first key byte and rises on the 16th.
- Output backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid rises.
  - Response: out_data stable, in_ready=0 and offered bytes ignored; a single transfer when out_ready rises.
- Reuse without a key:
  - Stimulus: directly after reset, send in_reuse_key=1 followed by 32 bytes of Appendix B data.
  - Response: the bytes are treated as key then plaintext; output 3925841d…0b32.
- Reset mid-operation:
  - Stimulus: pulse rst after 20 accepted bytes, then again during OUTPUT.
  - Response: every output is at its reset value next cycle, out_valid=0, key_loaded=0, in_ready=1, and the next byte is key byte 0.
